mult_seq: RTL
=============

MULT_SEQ -- requirements
Module: mult_seq

Interface
REQ-001 Parameter: SUPPORT_SIGNED, 1; when 0, signed_op SHALL be ignored and every operation treated as unsigned.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 signed_op  input  1  1 = MULT (two's complement), 0 = MULTU; sampled with start.
REQ-006 a  input  32  multiplicand; sampled with start.
REQ-007 b  input  32  multiplier; sampled with start.
REQ-008 busy  output  1  high from the cycle after start is accepted until done is asserted.
REQ-009 done  output  1  one-cycle pulse; hi/lo valid from this cycle.
REQ-010 hi  output  32  product bits [63:32].
REQ-011 lo  output  32  product bits [31:0].

Function
REQ-012 States SHALL be IDLE, RUN and FIX; each state change occurs only on a rising clk edge.
REQ-013 IDLE with start=1: capture |a| and |b| (magnitudes when signed_op=1 and SUPPORT_SIGNED=1, else raw), capture neg = a[31]^b[31] (signed only, else 0), clear the 33-bit accumulator, load the multiplier magnitude into the shift register, clear the 5-bit counter, then go to RUN.
REQ-014 Magnitude of 0x80000000 SHALL be 0x80000000, treated as an unsigned 32-bit value.
REQ-015 RUN, every cycle: if shift-register bit 0 = 1, {carry, sum} = acc[31:0] + mcand (32-bit carry-lookahead add, Cin=0), else {carry, sum} = {0, acc[31:0]}; then shift {carry, sum, shreg} right by 1 into {acc, shreg}; counter increments.
REQ-016 RUN SHALL last exactly 32 cycles; at counter = 31 the next state is FIX.
REQ-017 FIX: if neg=1, register the 64-bit two's complement of {acc[31:0], shreg} into {hi, lo}, else register it unchanged; assert done for that one cycle; next state IDLE.
REQ-018 Latency: start sampled at edge N produces done high in the cycle after edge N+33 (34 edges in total); throughput is one operation per 34 cycles.
REQ-019 start while busy=1 SHALL be ignored, with no queuing and no effect on the operation in flight.
REQ-020 start high in the same cycle as done SHALL be accepted, because the state is already IDLE; operations run back-to-back without a gap.
REQ-021 hi/lo SHALL hold their last result until the next FIX; they SHALL NOT change during RUN.
REQ-022 Changes on a, b or signed_op after the capture edge SHALL have no effect on the result.
REQ-023 A zero operand SHALL still take the full 34 cycles, with result 0 and no negative zero.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, busy=0, done=0, hi=0, lo=0 and clear the counter, accumulator and neg; this holds mid-operation with no pending done.
REQ-025 After rst_n deasserts, the first accepted start SHALL behave exactly as in REQ-013.

Structure
REQ-026 State encoding, the cycle count 32 and the product width 64 SHALL live in the shared ALU package.
REQ-027 The RUN-stage addition SHALL instantiate the team's cla_32 as the single sub-module, with Cin tied to 0 and its Cout as the accumulator carry; negation and magnitude logic stay local.

Verification
REQ-028 Unsigned: a=3, b=5 -> done at 34 cycles, hi=0x00000000, lo=0x0000000F.
REQ-029 Unsigned: a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; signed with the same operands -> hi=0x00000000, lo=0x00000001.
REQ-030 Signed: a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; signed a=b=0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-031 Second start pulsed at cycle 10 of an operation -> ignored; exactly one done; first result intact.
REQ-032 rst_n pulled low at RUN cycle 16 -> busy/done/hi/lo are 0 immediately, no done follows; a fresh 7x6 afterwards -> lo=0x0000002A.
REQ-033 start held high continuously -> done pulses every 34 cycles; busy low only in the done cycle.

Source files
------------

// File: rtl/mult_seq_pkg.sv
// mult_seq_pkg: shared state encoding and sizing for the sequential multiplier.
package mult_seq_pkg;
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    localparam int CYCLES = 32;
    localparam int PROD_W = 64;
endpackage

// File: rtl/mult_seq_cla.sv
// cla_32: 32-bit adder of 4-bit carry-lookahead groups chained by group generate/propagate.
module cla_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    logic [31:0] g, p, c;
    logic [8:0]  gc;
    assign g = a & b;
    assign p = a ^ b;
    assign gc[0] = cin;
    for (genvar k = 0; k < 8; k++) begin : grp
        logic [3:0] gg, pp;
        logic       ci, g_grp, p_grp;
        assign gg = g[4*k +: 4];
        assign pp = p[4*k +: 4];
        assign ci = gc[k];
        assign c[4*k]     = ci;
        assign c[4*k + 1] = gg[0] | (pp[0] & ci);
        assign c[4*k + 2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & ci);
        assign c[4*k + 3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0]) | (pp[2] & pp[1] & pp[0] & ci);
        assign g_grp = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1]) | (pp[3] & pp[2] & pp[1] & gg[0]);
        assign p_grp = &pp;
        assign gc[k + 1] = g_grp | (p_grp & ci);
    end
    assign sum  = p ^ c;
    assign cout = gc[8];
endmodule

// File: rtl/mult_seq.sv
// mult_seq: 32x32 shift-add multiplier on operand magnitudes, sign applied once in FIX.
import mult_seq_pkg::*;
module mult_seq #(
    parameter bit SUPPORT_SIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    state_t              state;
    logic [31:0]         mcand, shreg, mag_a, mag_b, sum;
    logic [32:0]         acc;
    logic [4:0]          cnt;
    logic                neg, sgn, carry;
    logic [PROD_W-1:0]   prod, res;
    assign sgn   = SUPPORT_SIGNED & signed_op;
    assign mag_a = (sgn && a[31]) ? -a : a;
    assign mag_b = (sgn && b[31]) ? -b : b;
    cla_32 u_cla (
        .a    (acc[31:0]),
        .b    (shreg[0] ? mcand : 32'd0),
        .cin  (1'b0),
        .sum  (sum),
        .cout (carry)
    );
    // acc[32] is always zero after a shift, so truncation keeps exactly {acc[31:0], shreg}
    assign prod = PROD_W'({acc, shreg});
    assign res  = neg ? -prod : prod;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            cnt   <= '0;
            acc   <= '0;
            neg   <= 1'b0;
            mcand <= '0;
            shreg <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    mcand <= mag_a;
                    shreg <= mag_b;
                    acc   <= '0;
                    cnt   <= '0;
                    neg   <= sgn & (a[31] ^ b[31]);
                    busy  <= 1'b1;
                    state <= RUN;
                end
                RUN: begin
                    acc   <= {1'b0, carry, sum[31:1]};
                    shreg <= {sum[0], shreg[31:1]};
                    cnt   <= cnt + 5'd1;
                    if (cnt == 5'(CYCLES - 1)) state <= FIX;
                end
                FIX: begin
                    {hi, lo} <= res;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
